// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard control unit.
//   - FSM state encoding (RUN / LU_STALL / FLUSH / MUL_HOLD)
//   - default register-specifier width
//   - architectural zero register (never a hazard source)
package hazard_pkg;

  localparam int HZ_REG_W = 5;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_LU_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSH    = 2'd2;
  localparam logic [1:0] ST_MUL_HOLD = 2'd3;

  localparam logic [HZ_REG_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/hazard_detect.sv
// Pure combinational load-use comparator.
// Ports:
//   ID_Rs, ID_Rt  in  REG_W  source specifiers of the instruction in ID
//   ID_UsesRt     in  1      ID instruction really reads rt
//   EX_MemRead    in  1      instruction in EX is a load
//   EX_Rt         in  REG_W  load destination in EX
//   LoadUseHit    out 1      ID needs the value the EX load has not produced yet
module hazard_detect
  import hazard_pkg::*;
#(
  parameter int REG_W = HZ_REG_W
) (
  input  logic [REG_W-1:0] ID_Rs,
  input  logic [REG_W-1:0] ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             EX_MemRead,
  input  logic [REG_W-1:0] EX_Rt,
  output logic             LoadUseHit
);

  logic dest_live;

  // Loads targeting $zero write nothing, so they can never feed a consumer.
  assign dest_live  = EX_MemRead && (EX_Rt != REG_W'(ZERO_REG));
  assign LoadUseHit = dest_live &&
                      ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer for the 5-stage MIPS core.
// Decides each cycle whether IF/ID captures, holds or is cleared and whether
// the PC advances. Outputs are decoded combinationally from the registered
// state plus the current inputs, so every hazard response is zero-cycle.
//
// Ports:
//   Clock         in   1      rising-edge clock
//   Reset         in   1      synchronous, active-high
//   ID_Rs/ID_Rt   in   REG_W  source specifiers in ID
//   ID_UsesRt     in   1      ID instruction reads rt
//   EX_MemRead    in   1      EX instruction is a load
//   EX_Rt         in   REG_W  load destination in EX
//   BranchTaken   in   1      redirect resolved this cycle
//   MulBusy       in   1      multi-cycle multiply occupies EX
//   PCWrite       out  1      PC register updates
//   PCSel         out  1      select redirect target, clear IF/ID
//   Stall_ID      out  1      IF/ID holds
//   ID_EX_Bubble  out  1      ID/EX loads a NOP
//   StallCount    out  32     (HAZARD_STATS_EN only) stall cycles seen
//   FlushCount    out  32     (HAZARD_STATS_EN only) redirect/flush cycles seen
//   FsmState      out  2      current FSM state, for debug/observation
//
// Build option: define HAZARD_STATS_EN to add the saturating statistics
// counters and their ports.
//
// Handshake note: there is no valid/ready pairing here; every output is a
// per-cycle level that the pipeline registers obey on the next rising edge.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int REG_W        = HZ_REG_W,
  parameter int FLUSH_CYC    = 1,
  parameter int LU_STALL_CYC = 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [REG_W-1:0] ID_Rs,
  input  logic [REG_W-1:0] ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             EX_MemRead,
  input  logic [REG_W-1:0] EX_Rt,
  input  logic             BranchTaken,
  input  logic             MulBusy,
  output logic             PCWrite,
  output logic             PCSel,
  output logic             Stall_ID,
  output logic             ID_EX_Bubble,
`ifdef HAZARD_STATS_EN
  output logic [31:0]      StallCount,
  output logic [31:0]      FlushCount,
`endif
  output logic [1:0]       FsmState
);

  localparam int MAX_CYC = (FLUSH_CYC > LU_STALL_CYC) ? FLUSH_CYC : LU_STALL_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  // Where a redirect / load-use response goes next. A single-cycle window
  // needs no dedicated state: the triggering RUN cycle already covers it.
  localparam logic [1:0]       REDIR_STATE = (FLUSH_CYC > 1) ? ST_FLUSH : ST_RUN;
  localparam logic [CNT_W-1:0] REDIR_CNT   = (FLUSH_CYC > 1) ? CNT_W'(FLUSH_CYC - 1) : '0;
  localparam logic [1:0]       LU_STATE    = (LU_STALL_CYC > 1) ? ST_LU_STALL : ST_RUN;
  localparam logic [CNT_W-1:0] LU_CNT      = (LU_STALL_CYC > 1) ? CNT_W'(LU_STALL_CYC - 1) : '0;

  logic [1:0]       state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             load_use_hit;

  hazard_detect #(
    .REG_W (REG_W)
  ) u_detect (
    .ID_Rs      (ID_Rs),
    .ID_Rt      (ID_Rt),
    .ID_UsesRt  (ID_UsesRt),
    .EX_MemRead (EX_MemRead),
    .EX_Rt      (EX_Rt),
    .LoadUseHit (load_use_hit)
  );

  assign FsmState = state_q;

  always_comb begin
    PCWrite      = 1'b1;
    PCSel        = 1'b0;
    Stall_ID     = 1'b0;
    ID_EX_Bubble = 1'b0;
    state_nxt    = state_q;
    cnt_nxt      = cnt_q;

    // While Reset is high the pipeline sees plain RUN outputs; the edge
    // itself returns the FSM to RUN with a cleared counter.
    if (!Reset) begin
      case (state_q)
        ST_RUN: begin
          if (BranchTaken) begin
            PCSel     = 1'b1;
            state_nxt = REDIR_STATE;
            cnt_nxt   = REDIR_CNT;
          end else if (MulBusy) begin
            PCWrite      = 1'b0;
            Stall_ID     = 1'b1;
            ID_EX_Bubble = 1'b1;
            state_nxt    = ST_MUL_HOLD;
          end else if (load_use_hit) begin
            PCWrite      = 1'b0;
            Stall_ID     = 1'b1;
            ID_EX_Bubble = 1'b1;
            state_nxt    = LU_STATE;
            cnt_nxt      = LU_CNT;
          end
        end

        ST_LU_STALL: begin
          // A resolved redirect makes the stalled instruction dead, so it
          // is abandoned and the flush window starts instead.
          if (BranchTaken) begin
            PCSel     = 1'b1;
            state_nxt = REDIR_STATE;
            cnt_nxt   = REDIR_CNT;
          end else begin
            PCWrite      = 1'b0;
            Stall_ID     = 1'b1;
            ID_EX_Bubble = 1'b1;
            if (cnt_q <= CNT_W'(1)) begin
              state_nxt = ST_RUN;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt_q - CNT_W'(1);
            end
          end
        end

        ST_FLUSH: begin
          // IF/ID is held clear and the PC keeps fetching down the new path.
          // Inputs are ignored: ID/EX only holds squashed bubbles here.
          Stall_ID     = 1'b1;
          ID_EX_Bubble = 1'b1;
          if (cnt_q <= CNT_W'(1)) begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_q - CNT_W'(1);
          end
        end

        default: begin  // ST_MUL_HOLD
          if (BranchTaken) begin
            PCSel     = 1'b1;
            state_nxt = REDIR_STATE;
            cnt_nxt   = REDIR_CNT;
          end else if (MulBusy) begin
            PCWrite      = 1'b0;
            Stall_ID     = 1'b1;
            ID_EX_Bubble = 1'b1;
          end else begin
            // Release cycle: the pipeline moves on with normal outputs.
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

`ifdef HAZARD_STATS_EN
  logic stall_evt, flush_evt;

  assign stall_evt = Stall_ID && !PCSel;
  assign flush_evt = PCSel || (state_q == ST_FLUSH);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (stall_evt && (StallCount != 32'hFFFF_FFFF))
        StallCount <= StallCount + 32'd1;
      if (flush_evt && (FlushCount != 32'hFFFF_FFFF))
        FlushCount <= FlushCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit. Two instances share all inputs:
//   dut 0: FLUSH_CYC=1, LU_STALL_CYC=1 (default build)
//   dut 1: FLUSH_CYC=3, LU_STALL_CYC=2
// Expected outputs come from a cycle model built on remaining-cycle budgets.
module tb_hazard_control_unit;

  localparam int NDUT = 2;

  logic       clock;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_read, branch_taken, mul_busy;

  logic       pc_write [NDUT];
  logic       pc_sel   [NDUT];
  logic       stall_id [NDUT];
  logic       bubble   [NDUT];
  logic [1:0] fsm_state[NDUT];
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count[NDUT];
  logic [31:0] flush_count[NDUT];
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state: cycles still owed to each kind of hold.
  int flush_left[NDUT];
  int lu_left   [NDUT];
  bit in_mul    [NDUT];
  int exp_stall_cnt[NDUT];
  int exp_flush_cnt[NDUT];

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  hazard_control_unit #(.REG_W(5), .FLUSH_CYC(1), .LU_STALL_CYC(1)) dut0 (
    .Clock        (clock),
    .Reset        (reset),
    .ID_Rs        (id_rs),
    .ID_Rt        (id_rt),
    .ID_UsesRt    (id_uses_rt),
    .EX_MemRead   (ex_mem_read),
    .EX_Rt        (ex_rt),
    .BranchTaken  (branch_taken),
    .MulBusy      (mul_busy),
    .PCWrite      (pc_write[0]),
    .PCSel        (pc_sel[0]),
    .Stall_ID     (stall_id[0]),
    .ID_EX_Bubble (bubble[0]),
`ifdef HAZARD_STATS_EN
    .StallCount   (stall_count[0]),
    .FlushCount   (flush_count[0]),
`endif
    .FsmState     (fsm_state[0])
  );

  hazard_control_unit #(.REG_W(5), .FLUSH_CYC(3), .LU_STALL_CYC(2)) dut1 (
    .Clock        (clock),
    .Reset        (reset),
    .ID_Rs        (id_rs),
    .ID_Rt        (id_rt),
    .ID_UsesRt    (id_uses_rt),
    .EX_MemRead   (ex_mem_read),
    .EX_Rt        (ex_rt),
    .BranchTaken  (branch_taken),
    .MulBusy      (mul_busy),
    .PCWrite      (pc_write[1]),
    .PCSel        (pc_sel[1]),
    .Stall_ID     (stall_id[1]),
    .ID_EX_Bubble (bubble[1]),
`ifdef HAZARD_STATS_EN
    .StallCount   (stall_count[1]),
    .FlushCount   (flush_count[1]),
`endif
    .FsmState     (fsm_state[1])
  );

  function automatic int f_cyc(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int l_cyc(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver + model ----------------
  // One cycle: drive at the falling edge, check after settling, advance the
  // model as the following rising edge will.
  task automatic step(input logic rst, input logic bt, input logic mb,
                      input logic mr, input logic ur,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ert);
    @(negedge clock);
    reset        = rst;
    branch_taken = bt;
    mul_busy     = mb;
    ex_mem_read  = mr;
    id_uses_rt   = ur;
    id_rs        = rs;
    id_rt        = rt;
    ex_rt        = ert;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      logic e_pcw, e_sel, e_stall, e_bub, hit, was_flush;
      hit       = mr && (ert != 5'd0) && ((ert == rs) || (ur && (ert == rt)));
      was_flush = (flush_left[k] > 0);
      e_pcw = 1'b1; e_sel = 1'b0; e_stall = 1'b0; e_bub = 1'b0;
      if (rst) begin
        flush_left[k] = 0; lu_left[k] = 0; in_mul[k] = 1'b0;
      end else if (flush_left[k] > 0) begin
        e_stall = 1'b1; e_bub = 1'b1;
        flush_left[k]--;
      end else if (bt) begin
        e_sel = 1'b1;
        flush_left[k] = f_cyc(k) - 1; lu_left[k] = 0; in_mul[k] = 1'b0;
      end else if (in_mul[k]) begin
        if (mb) begin e_pcw = 1'b0; e_stall = 1'b1; e_bub = 1'b1; end
        else in_mul[k] = 1'b0;
      end else if (lu_left[k] > 0) begin
        e_pcw = 1'b0; e_stall = 1'b1; e_bub = 1'b1;
        lu_left[k]--;
      end else if (mb) begin
        e_pcw = 1'b0; e_stall = 1'b1; e_bub = 1'b1;
        in_mul[k] = 1'b1;
      end else if (hit) begin
        e_pcw = 1'b0; e_stall = 1'b1; e_bub = 1'b1;
        lu_left[k] = l_cyc(k) - 1;
      end
      chk($sformatf("dut%0d PCWrite t=%0t", k, $time),  32'(pc_write[k]), 32'(e_pcw));
      chk($sformatf("dut%0d PCSel t=%0t", k, $time),    32'(pc_sel[k]),   32'(e_sel));
      chk($sformatf("dut%0d Stall_ID t=%0t", k, $time), 32'(stall_id[k]), 32'(e_stall));
      chk($sformatf("dut%0d Bubble t=%0t", k, $time),   32'(bubble[k]),   32'(e_bub));
`ifdef HAZARD_STATS_EN
      if (!rst) begin
        chk($sformatf("dut%0d StallCount t=%0t", k, $time), stall_count[k], 32'(exp_stall_cnt[k]));
        chk($sformatf("dut%0d FlushCount t=%0t", k, $time), flush_count[k], 32'(exp_flush_cnt[k]));
      end
`endif
      if (rst) begin
        exp_stall_cnt[k] = 0;
        exp_flush_cnt[k] = 0;
      end else begin
        if (e_stall && !e_sel) exp_stall_cnt[k]++;
        if (e_sel || was_flush) exp_flush_cnt[k]++;
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int mul_left;
    logic rb, rr;
    reset = 1'b1; branch_taken = 1'b0; mul_busy = 1'b0; ex_mem_read = 1'b0;
    id_uses_rt = 1'b0; id_rs = '0; id_rt = '0; ex_rt = '0;
    for (int k = 0; k < NDUT; k++) begin
      flush_left[k] = 0; lu_left[k] = 0; in_mul[k] = 1'b0;
      exp_stall_cnt[k] = 0; exp_flush_cnt[k] = 0;
    end

    // reset for two cycles, then quiet pipeline
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    repeat (3) idle();

    // load-use through rs
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd8, 5'd0, 5'd8);
    repeat (3) idle();

    // $zero destination and unused rt never hazard
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 5'd8, 5'd8);
    // rt hazard when rt is really read
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 5'd8, 5'd8);
    repeat (2) idle();

    // redirect beats a simultaneous load-use hit
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd8, 5'd0, 5'd8);
    repeat (4) idle();

    // multiply busy for four cycles, then release
    repeat (4) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    repeat (2) idle();

    // plain redirect: flush window on the 3-cycle instance
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    repeat (4) idle();

    // redirect arriving while a load-use stall is in progress
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 5'd0, 5'd5);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 5'd0, 5'd5);
    repeat (4) idle();

    // redirect during a multiply hold
    repeat (2) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    repeat (4) idle();

    // reset while held by a multiply
    repeat (2) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    repeat (2) idle();

    // reset in the middle of a flush window
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    repeat (2) idle();

    // randomized traffic: small register range to provoke hits
    mul_left = 0;
    for (int i = 0; i < 500; i++) begin
      if (mul_left == 0 && $urandom_range(0, 9) == 0) mul_left = $urandom_range(1, 5);
      rb = ($urandom_range(0, 7) == 0);
      rr = ($urandom_range(0, 63) == 0);
      step(rr, rb, (mul_left > 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      if (mul_left > 0) mul_left--;
    end
    repeat (4) idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
